// File: rtl/softmax_row_stream.sv
// Streaming row-wise simplified softmax: buffers one score row, tracks its signed minimum,
// then replays each beat as saturated, quantised (x - min)^2 per lane.
module softmax_row_stream #(
    parameter int IN_W      = 16,
    parameter int IN_FRAC   = 8,
    parameter int OUT_W     = 16,
    parameter int OUT_FRAC  = 8,
    parameter int LANES     = 4,
    parameter int MAX_BEATS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W*LANES-1:0]  in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W*LANES-1:0] out_data,
    output logic                   out_last,
    output logic                   row_trunc,
    output logic                   busy
);

    localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int D_W   = IN_W + 1;
    localparam int SQ_W  = 2 * IN_W + 2;
    localparam int SHIFT = 2 * IN_FRAC - OUT_FRAC;

    typedef enum logic {LOAD, EMIT} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        wr_cnt_reg, wr_cnt_next;
    logic [CNT_W-1:0]        rd_cnt_reg, rd_cnt_next;
    logic [CNT_W-1:0]        last_reg, last_next;
    logic signed [IN_W-1:0]  min_reg, min_next;
    logic signed [IN_W-1:0]  beat_min;
    logic                    trunc_reg, trunc_next;
    logic                    wr_at_end;
    logic                    rd_at_last;
    logic                    in_fire;

    logic [IN_W*LANES-1:0]   row_mem [MAX_BEATS];
    logic [IN_W*LANES-1:0]   rd_word;

    assign in_fire    = in_valid & in_ready;
    assign wr_at_end  = (wr_cnt_reg == CNT_W'(MAX_BEATS - 1));
    assign rd_at_last = (rd_cnt_reg == last_reg);
    assign row_trunc  = trunc_reg;

    always_comb begin
        beat_min = in_data[IN_W-1:0];
        for (int k = 1; k < LANES; k++) begin
            if ($signed(in_data[IN_W*k +: IN_W]) < beat_min)
                beat_min = in_data[IN_W*k +: IN_W];
        end
    end

    // Row buffer keeps its contents across reset; only the counters are cleared.
    always_ff @(posedge clk) begin
        if (in_fire)
            row_mem[wr_cnt_reg] <= in_data;
    end

    assign rd_word = row_mem[rd_cnt_reg];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [D_W-1:0]  d;
            logic [SQ_W-1:0] sq;
            logic [SQ_W-1:0] q;
            // The difference is never negative, so it is squared as an unsigned value.
            assign d  = {rd_word[IN_W*gi+IN_W-1], rd_word[IN_W*gi +: IN_W]}
                      - {min_reg[IN_W-1], min_reg};
            assign sq = SQ_W'(d) * SQ_W'(d);
            assign q  = sq >> SHIFT;
            assign out_data[OUT_W*gi +: OUT_W] = (|q[SQ_W-1:OUT_W]) ? {OUT_W{1'b1}} : q[OUT_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= LOAD;
            wr_cnt_reg <= '0;
            rd_cnt_reg <= '0;
            last_reg   <= '0;
            min_reg    <= '0;
            trunc_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wr_cnt_reg <= wr_cnt_next;
            rd_cnt_reg <= rd_cnt_next;
            last_reg   <= last_next;
            min_reg    <= min_next;
            trunc_reg  <= trunc_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        wr_cnt_next = wr_cnt_reg;
        rd_cnt_next = rd_cnt_reg;
        last_next   = last_reg;
        min_next    = min_reg;
        trunc_next  = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        busy        = 1'b0;
        case (state_reg)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_cnt_next = wr_cnt_reg + 1'b1;
                    if (wr_cnt_reg == '0 || beat_min < min_reg)
                        min_next = beat_min;
                    if (in_last || wr_at_end) begin
                        last_next   = wr_cnt_reg;
                        wr_cnt_next = '0;
                        trunc_next  = ~in_last;
                        state_next  = EMIT;
                    end
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = rd_at_last;
                if (out_ready) begin
                    if (rd_at_last) begin
                        rd_cnt_next = '0;
                        state_next  = LOAD;
                    end else begin
                        rd_cnt_next = rd_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = LOAD;
        endcase
    end

endmodule
